// File: rtl/digit_preset_sequencer.sv
// digit_preset_sequencer: holds a preset index selected by debounced push
// buttons or a timed auto-step, and drives a packed BCD bus for a
// seven-segment scan driver. Button priority is C > D > R > L > U.
module digit_preset_sequencer #(
   parameter int NUM_DIGITS      = 4,
   parameter int NUM_PRESETS     = 5,
   parameter logic [NUM_PRESETS*NUM_DIGITS*4-1:0] PRESET_TABLE =
      {16'h5310, 16'h5000, 16'h0300, 16'h0010, 16'h0000},
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_PERIOD     = 50_000_000
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [1:0]                           sw,
   input  logic                                 btnU,
   input  logic                                 btnL,
   input  logic                                 btnR,
   input  logic                                 btnD,
   input  logic                                 btnC,
   output logic [$clog2(NUM_PRESETS+2)-1:0]     state,
   output logic [NUM_DIGITS*4-1:0]              digits,
   output logic                                 changed
);

   localparam int IW = $clog2(NUM_PRESETS + 2);
   localparam int XW = IW + 1;
   localparam int DW = NUM_DIGITS * 4;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(AUTO_PERIOD);

   localparam logic [IW-1:0] ONES_IDX  = IW'(NUM_PRESETS);
   localparam logic [IW-1:0] NINES_IDX = IW'(NUM_PRESETS + 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_PRESETS - 1);
   localparam logic [XW-1:0] NP_X      = XW'(NUM_PRESETS);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_PERIOD - 1);

   // Button vector order doubles as priority order: bit 0 wins.
   logic [4:0]    btn_raw;
   logic [4:0]    sync1_q, sync2_q;
   logic [4:0]    deb_q, deb_prev_q;
   logic [CW-1:0] cnt_q [5];
   logic [4:0]    press;

   logic [TW-1:0] tick_q, tick_d;
   logic [1:0]    sw_q;
   logic [IW-1:0] state_q, state_d;
   logic [IW-1:0] shown_q;
   logic [DW-1:0] digits_q;
   logic          changed_q;

   logic          auto_en, mode_change, step_fire;
   logic [XW-1:0] up_sum, dn_sum;
   logic [IW-1:0] up_idx, dn_idx;

   assign btn_raw = {btnU, btnL, btnR, btnD, btnC};
   assign press   = deb_q & ~deb_prev_q;

   // Display pattern for an index; out-of-map indices show all zeros.
   function automatic logic [DW-1:0] decode(input logic [IW-1:0] idx);
      logic [DW-1:0] r;
      r = {DW{1'b0}};
      if (idx == ONES_IDX) begin
         r = {NUM_DIGITS{4'h1}};
      end else if (idx == NINES_IDX) begin
         r = {NUM_DIGITS{4'h9}};
      end else begin
         for (int p = 0; p < NUM_PRESETS; p++) begin
            if (idx == IW'(p)) begin
               r = PRESET_TABLE[p*DW +: DW];
            end else begin
               r = r;
            end
         end
      end
      return r;
   endfunction

   // Two-flop synchroniser, per-button debounce counter and edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 5'b00000;
         sync2_q    <= 5'b00000;
         deb_q      <= 5'b00000;
         deb_prev_q <= 5'b00000;
         for (int b = 0; b < 5; b++) begin
            cnt_q[b] <= {CW{1'b0}};
         end
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int b = 0; b < 5; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
               if (cnt_q[b] == DEB_LAST) begin
                  deb_q[b] <= ~deb_q[b];
                  cnt_q[b] <= {CW{1'b0}};
               end else begin
                  cnt_q[b] <= cnt_q[b] + CW'(1);
               end
            end else begin
               cnt_q[b] <= {CW{1'b0}};
            end
         end
      end
   end

   // Next index: prioritised presses first, then the auto step.
   always_comb begin
      auto_en     = (sw == 2'b01) || (sw == 2'b10);
      mode_change = (sw != sw_q);
      step_fire   = auto_en && !mode_change && (tick_q == TICK_LAST);

      // Wrap arithmetic is one bit wider than the index so it cannot overflow.
      up_sum = {1'b0, state_q} + XW'(1);
      dn_sum = {1'b0, state_q} + XW'(NUM_PRESETS - 1);
      if (state_q < ONES_IDX) begin
         up_idx = (up_sum >= NP_X) ? IW'(up_sum - NP_X) : up_sum[IW-1:0];
         dn_idx = (dn_sum >= NP_X) ? IW'(dn_sum - NP_X) : dn_sum[IW-1:0];
      end else if ((state_q == ONES_IDX) || (state_q == NINES_IDX)) begin
         up_idx = {IW{1'b0}};
         dn_idx = LAST_IDX;
      end else begin
         up_idx = {IW{1'b0}};
         dn_idx = {IW{1'b0}};
      end

      // Any press, a mode change or manual mode restarts the period.
      if (!auto_en || mode_change || (press != 5'b00000)) begin
         tick_d = {TW{1'b0}};
      end else if (tick_q == TICK_LAST) begin
         tick_d = {TW{1'b0}};
      end else begin
         tick_d = tick_q + TW'(1);
      end

      if (press[0]) begin
         state_d = {IW{1'b0}};
      end else if (press[1]) begin
         state_d = NINES_IDX;
      end else if (press[2]) begin
         state_d = IW'(1);
      end else if (press[3]) begin
         state_d = IW'(2);
      end else if (press[4]) begin
         state_d = ONES_IDX;
      end else if (step_fire) begin
         state_d = (sw == 2'b01) ? up_idx : dn_idx;
      end else begin
         state_d = state_q;
      end
   end

   // Index, tick counter and registered display/pulse outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= {IW{1'b0}};
         shown_q   <= {IW{1'b0}};
         tick_q    <= {TW{1'b0}};
         digits_q  <= {DW{1'b0}};
         changed_q <= 1'b0;
         sw_q      <= sw;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         sw_q      <= sw;
         digits_q  <= decode(state_q);
         changed_q <= (state_q != shown_q);
         shown_q   <= state_q;
      end
   end

   assign state   = state_q;
   assign digits  = digits_q;
   assign changed = changed_q;

endmodule
